// File: rtl/pdn.sv
// Bufferless 2x2-of-2x2 deflection router: four flits in, the same four flits
// out one cycle later, steered by golden priority, route fields and fixed tie-breaks.
module pdn #(
  parameter int FLIT_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] north_in,
  input  logic [FLIT_W-1:0] south_in,
  input  logic [FLIT_W-1:0] west_in,
  input  logic [FLIT_W-1:0] east_in,
  output logic [FLIT_W-1:0] north_out,
  output logic [FLIT_W-1:0] south_out,
  output logic [FLIT_W-1:0] east_out,
  output logic [FLIT_W-1:0] west_out
);

  localparam int GOLD_BIT = 9;
  localparam int VERT_BIT = 7;
  localparam int VDIR_BIT = 6;
  localparam int HDIR_BIT = 2;

  typedef logic [FLIT_W-1:0] flit_t;

  // Stage-1 result: one flit towards the vertical block, one towards the horizontal.
  typedef struct packed {
    flit_t v;
    flit_t h;
  } half_pair_t;

  // Stage-2 result: sel1 is the output chosen by direction bit 1 (south/east).
  typedef struct packed {
    flit_t sel1;
    flit_t sel0;
  } port_pair_t;

  function automatic half_pair_t stage1(input flit_t first, input flit_t second);
    half_pair_t res;
    logic       first_wins;
    flit_t      win;
    flit_t      lose;
    // The second input only wins when it alone is golden.
    first_wins = first[GOLD_BIT] | ~second[GOLD_BIT];
    win        = first_wins ? first  : second;
    lose       = first_wins ? second : first;
    res.v      = win[VERT_BIT] ? win  : lose;
    res.h      = win[VERT_BIT] ? lose : win;
    return res;
  endfunction

  function automatic port_pair_t stage2(input flit_t a, input flit_t b,
                                        input logic home_vert,
                                        input logic a_dir, input logic b_dir);
    port_pair_t res;
    logic       a_home;
    logic       b_home;
    logic       a_wins;
    logic       win_dir;
    flit_t      win;
    flit_t      lose;
    a_home = (a[VERT_BIT] == home_vert);
    b_home = (b[VERT_BIT] == home_vert);
    // Golden first, then correctly-routed over misrouted, then block A.
    if (a[GOLD_BIT] != b[GOLD_BIT]) begin
      a_wins = a[GOLD_BIT];
    end else begin
      a_wins = a_home | ~b_home;
    end
    win      = a_wins ? a : b;
    lose     = a_wins ? b : a;
    win_dir  = a_wins ? a_dir : b_dir;
    res.sel1 = win_dir ? win  : lose;
    res.sel0 = win_dir ? lose : win;
    return res;
  endfunction

  half_pair_t blk_a;
  half_pair_t blk_b;
  port_pair_t blk_v;
  port_pair_t blk_h;

  // NOTE: every signal driven here is fully assigned on every evaluation, so no latch is inferred.
  always_comb begin
    blk_a = stage1(north_in, east_in);
    blk_b = stage1(south_in, west_in);
    blk_v = stage2(blk_a.v, blk_b.v, 1'b1, blk_a.v[VDIR_BIT], blk_b.v[VDIR_BIT]);
    blk_h = stage2(blk_a.h, blk_b.h, 1'b0, blk_a.h[HDIR_BIT], blk_b.h[HDIR_BIT]);
  end

  // NOTE: registers use non-blocking assignment so all four outputs update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      north_out <= '0;
      south_out <= '0;
      east_out  <= '0;
      west_out  <= '0;
    end else begin
      south_out <= blk_v.sel1;
      north_out <= blk_v.sel0;
      east_out  <= blk_h.sel1;
      west_out  <= blk_h.sel0;
    end
  end

endmodule

// File: tb/tb_pdn.sv
// Directed and randomised checks of the pdn deflection router: fixed scenarios,
// latency, asynchronous reset, and permutation/reference checks on random flits.
module tb_pdn;

  logic       clk;
  logic       rst;
  logic [9:0] north_in, south_in, west_in, east_in;
  logic [9:0] north_out, south_out, east_out, west_out;

  int checks = 0;
  int errors = 0;

  pdn #(.FLIT_W(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .north_in (north_in),
    .south_in (south_in),
    .west_in  (west_in),
    .east_in  (east_in),
    .north_out(north_out),
    .south_out(south_out),
    .east_out (east_out),
    .west_out (west_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [9:0] en, input logic [9:0] es,
                            input logic [9:0] ee, input logic [9:0] ew);
    check({tag, ".north"}, north_out, en);
    check({tag, ".south"}, south_out, es);
    check({tag, ".east"},  east_out,  ee);
    check({tag, ".west"},  west_out,  ew);
  endtask

  task automatic drive(input logic [9:0] n, input logic [9:0] s,
                       input logic [9:0] e, input logic [9:0] w);
    north_in = n;
    south_in = s;
    east_in  = e;
    west_in  = w;
  endtask

  task automatic apply(input logic [9:0] n, input logic [9:0] s,
                       input logic [9:0] e, input logic [9:0] w);
    @(negedge clk);
    drive(n, s, e, w);
    @(posedge clk);
    #1;
  endtask

  // Reference router written straight from the field/priority rules.
  function automatic void ref_route(input logic [9:0] n, input logic [9:0] s,
                                    input logic [9:0] e, input logic [9:0] w,
                                    output logic [9:0] no, output logic [9:0] so,
                                    output logic [9:0] eo, output logic [9:0] wo);
    logic [9:0] av, ah, bv, bh, win, lose;
    logic       awin;
    if (e[9] && !n[9]) begin win = e; lose = n; end
    else begin win = n; lose = e; end
    if (win[7]) begin av = win; ah = lose; end
    else begin ah = win; av = lose; end
    if (w[9] && !s[9]) begin win = w; lose = s; end
    else begin win = s; lose = w; end
    if (win[7]) begin bv = win; bh = lose; end
    else begin bh = win; bv = lose; end
    if (av[9] != bv[9]) awin = av[9];
    else if (av[7] != bv[7]) awin = av[7];
    else awin = 1'b1;
    win  = awin ? av : bv;
    lose = awin ? bv : av;
    if (win[6]) begin so = win; no = lose; end
    else begin no = win; so = lose; end
    if (ah[9] != bh[9]) awin = ah[9];
    else if (ah[7] != bh[7]) awin = !ah[7];
    else awin = 1'b1;
    win  = awin ? ah : bh;
    lose = awin ? bh : ah;
    if (win[2]) begin eo = win; wo = lose; end
    else begin wo = win; eo = lose; end
  endfunction

  initial begin
    logic [9:0] pin [4];
    logic [9:0] pout[4];
    logic [9:0] rn, rs, re, rw;
    logic       used[4];
    logic       ok, found;

    rst = 1'b1;
    drive(10'b0011001100, 10'b0010101100, 10'b1010101100, 10'b0000100111);
    @(posedge clk);
    #1;
    check_outs("reset", 10'b0, 10'b0, 10'b0, 10'b0);
    @(negedge clk);
    rst = 1'b0;

    // Golden conflict: E golden takes north; W correctly routed beats misrouted N for east.
    apply(10'b0011001100, 10'b0010101100, 10'b1010101100, 10'b0000100111);
    check_outs("golden", 10'b1010101100, 10'b0010101100, 10'b0000100111, 10'b0011001100);

    // Latency: new inputs between edges must not show until the next edge.
    @(negedge clk);
    drive(10'b0011000100, 10'b1010101100, 10'b0001101101, 10'b0000011001);
    #1;
    check_outs("latency_hold", 10'b1010101100, 10'b0010101100, 10'b0000100111, 10'b0011001100);
    @(posedge clk);
    #1;
    check_outs("conflict_free", 10'b1010101100, 10'b0011000100, 10'b0001101101, 10'b0000011001);

    // All vertical: E and W deflected into the horizontal half, A wins ties.
    apply(10'b0011010100, 10'b0010110100, 10'b0011001100, 10'b0010110100);
    check_outs("all_vert", 10'b0010110100, 10'b0011010100, 10'b0011001100, 10'b0010110100);

    // Golden tie in block A: N wins; golden-but-misrouted E beats non-golden S in H.
    apply(10'b1011000000, 10'b0000000100, 10'b1010000000, 10'b0000000011);
    check_outs("golden_tie", 10'b0000000011, 10'b1011000000, 10'b0000000100, 10'b1010000000);

    // Asynchronous reset between edges, held across an edge, released before one.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_outs("async_rst", 10'b0, 10'b0, 10'b0, 10'b0);
    @(posedge clk);
    #1;
    check_outs("rst_held", 10'b0, 10'b0, 10'b0, 10'b0);
    @(negedge clk);
    rst = 1'b0;
    drive(10'b0011000100, 10'b1010101100, 10'b0001101101, 10'b0000011001);
    #1;
    check_outs("rst_released", 10'b0, 10'b0, 10'b0, 10'b0);
    @(posedge clk);
    #1;
    check_outs("first_after_rst", 10'b1010101100, 10'b0011000100, 10'b0001101101, 10'b0000011001);

    // Random flits: outputs must be a permutation of inputs and match the reference.
    for (int cyc = 0; cyc < 1000; cyc++) begin
      pin[0] = 10'($urandom);
      pin[1] = 10'($urandom);
      pin[2] = 10'($urandom);
      pin[3] = 10'($urandom);
      apply(pin[0], pin[1], pin[2], pin[3]);
      pout[0] = north_out;
      pout[1] = south_out;
      pout[2] = east_out;
      pout[3] = west_out;
      ok = 1'b1;
      for (int j = 0; j < 4; j++) used[j] = 1'b0;
      for (int i = 0; i < 4; i++) begin
        found = 1'b0;
        for (int j = 0; j < 4; j++) begin
          if (!found && !used[j] && pout[i] === pin[j]) begin
            used[j] = 1'b1;
            found   = 1'b1;
          end
        end
        if (!found) ok = 1'b0;
      end
      check("permutation", {9'b0, ok}, 10'd1);
      ref_route(pin[0], pin[1], pin[2], pin[3], rn, rs, re, rw);
      check("rand_route", {north_out ^ rn} | {south_out ^ rs} | {east_out ^ re} | {west_out ^ rw},
            10'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
